// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ENTRY,
        ST_RETURN,
        ST_REFILL
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_SW    = 4'd3;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_EXT   = 4'd11;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_csr.sv
// Machine-mode CSR file: registers, read mux and write decode.
// Define TRAP_VECTORED_EN to keep writable mtvec[1:0] (vectored mode select).
module trap_csr
    import trap_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          csr_we_i,
    input  logic [11:0]   csr_addr_i,
    input  logic [N-1:0]  csr_wdata_i,
    output logic [N-1:0]  csr_rdata_o,
    input  logic [2:0]    irq_i,
    input  logic          trap_take_i,
    input  logic          trap_irq_i,
    input  logic [3:0]    trap_cause_i,
    input  logic [N-1:0]  trap_pc_i,
    input  logic          mret_i,
    output logic [N-1:0]  mtvec_o,
    output logic [N-1:0]  mie_o,
    output logic [N-1:0]  mepc_o,
    output logic          mstatus_mie_o
);

    localparam logic [N-1:0] PC_MASK = ~(N'(3));
`ifdef TRAP_VECTORED_EN
    localparam logic [N-1:0] MTVEC_MASK = '1;
`else
    localparam logic [N-1:0] MTVEC_MASK = PC_MASK;
`endif

    logic [N-1:0] mtvec_q, mepc_q, mcause_q, mie_q;
    logic         mie_bit_q, mpie_q;

    // Trap entry / mret are written last so they win over a same-cycle CSR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mie_q     <= '0;
            mie_bit_q <= 1'b0;
            mpie_q    <= 1'b0;
        end else begin
            if (csr_we_i) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mie_bit_q <= csr_wdata_i[MSTATUS_MIE_BIT];
                        mpie_q    <= csr_wdata_i[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:    mie_q    <= csr_wdata_i;
                    CSR_MTVEC:  mtvec_q  <= csr_wdata_i & MTVEC_MASK;
                    CSR_MEPC:   mepc_q   <= csr_wdata_i & PC_MASK;
                    CSR_MCAUSE: mcause_q <= csr_wdata_i;
                    default: ;
                endcase
            end
            if (trap_take_i) begin
                mepc_q    <= trap_pc_i & PC_MASK;
                mcause_q  <= {trap_irq_i, {(N-5){1'b0}}, trap_cause_i};
                mpie_q    <= mie_bit_q;
                mie_bit_q <= 1'b0;
            end else if (mret_i) begin
                mie_bit_q <= mpie_q;
                mpie_q    <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE_BIT]  = mie_bit_q;
                csr_rdata_o[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MIE:    csr_rdata_o = mie_q;
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            CSR_MIP: begin
                csr_rdata_o[CAUSE_SW]    = irq_i[0];
                csr_rdata_o[CAUSE_TIMER] = irq_i[1];
                csr_rdata_o[CAUSE_EXT]   = irq_i[2];
            end
            default: ;
        endcase
    end

    assign mtvec_o       = mtvec_q;
    assign mie_o         = mie_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mie_bit_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: event arbitration, redirect FSM and post-redirect refill hold-off.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets (mtvec[1:0]=01).
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned N            = 64,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exc_valid,
    input  logic [3:0]    exc_cause,
    input  logic [N-1:0]  exc_pc,
    input  logic [2:0]    irq,
    input  logic          mret_req,
    input  logic          csr_we,
    input  logic [11:0]   csr_addr,
    input  logic [N-1:0]  csr_wdata,
    output logic [N-1:0]  csr_rdata,
    output logic          interruptSignal,
    output logic [N-1:0]  PC_TrapTrigger,
    output logic          trapReturn,
    output logic [N-1:0]  PC_TrapReturn,
    output logic          flush
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    trap_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             int_q, ret_q, flush_q;
    logic [N-1:0]     pc_trap_q;

    logic [N-1:0] mtvec_w, mie_w, mepc_w;
    logic         mstatus_mie_w;
    logic [2:0]   pend_c;
    logic         take_exc_c, take_irq_c, take_mret_c;
    logic [3:0]   irq_cause_c, trap_cause_c;
    logic [N-1:0] trap_target_c;

    // Arbitration in RUN: exception > enabled interrupt (ext > sw > timer) > mret.
    always_comb begin
        pend_c       = irq & {mie_w[CAUSE_EXT], mie_w[CAUSE_TIMER], mie_w[CAUSE_SW]}
                           & {3{mstatus_mie_w}};
        take_exc_c   = (state_q == ST_RUN) && exc_valid;
        take_irq_c   = (state_q == ST_RUN) && !exc_valid && (|pend_c);
        take_mret_c  = (state_q == ST_RUN) && !exc_valid && !(|pend_c) && mret_req;
        irq_cause_c  = pend_c[2] ? CAUSE_EXT : (pend_c[0] ? CAUSE_SW : CAUSE_TIMER);
        trap_cause_c = take_exc_c ? exc_cause : irq_cause_c;
        trap_target_c = mtvec_w & ~(N'(3));
`ifdef TRAP_VECTORED_EN
        if (!take_exc_c && (mtvec_w[1:0] == 2'b01))
            trap_target_c = (mtvec_w & ~(N'(3))) + N'({trap_cause_c, 2'b00});
`endif
    end

    // Target is captured at acceptance so a same-cycle mtvec write only affects later traps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            int_q     <= 1'b0;
            ret_q     <= 1'b0;
            flush_q   <= 1'b0;
            pc_trap_q <= '0;
        end else begin
            int_q <= 1'b0;
            ret_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (take_exc_c || take_irq_c) begin
                        state_q   <= ST_ENTRY;
                        int_q     <= 1'b1;
                        flush_q   <= 1'b1;
                        pc_trap_q <= trap_target_c;
                    end else if (take_mret_c) begin
                        state_q <= ST_RETURN;
                        ret_q   <= 1'b1;
                        flush_q <= 1'b1;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                ST_ENTRY, ST_RETURN: begin
                    if (FLUSH_CYCLES == 0) begin
                        state_q <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        state_q <= ST_REFILL;
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                        flush_q <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    trap_csr #(.N(N)) u_csr (
        .clk           (clk),
        .reset         (reset),
        .csr_we_i      (csr_we),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .irq_i         (irq),
        .trap_take_i   (take_exc_c || take_irq_c),
        .trap_irq_i    (!take_exc_c),
        .trap_cause_i  (trap_cause_c),
        .trap_pc_i     (exc_pc),
        .mret_i        (take_mret_c),
        .mtvec_o       (mtvec_w),
        .mie_o         (mie_w),
        .mepc_o        (mepc_w),
        .mstatus_mie_o (mstatus_mie_w)
    );

    assign interruptSignal = int_q;
    assign trapReturn      = ret_q;
    assign flush           = flush_q;
    assign PC_TrapTrigger  = pc_trap_q;
    assign PC_TrapReturn   = mepc_w;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, meaning PC/CSR data width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 3, meaning the number of refill cycles after any redirect during which new events are held off.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port exc_valid  input  1  synchronous exception request from retire.
REQ-006 SHALL have port exc_cause  input  4  exception cause code.
REQ-007 SHALL have port exc_pc  input  N  PC of the faulting instruction.
REQ-008 SHALL have port irq  input  3  level interrupts; bit0 software (cause 3), bit1 timer (cause 7), bit2 external (cause 11).
REQ-009 SHALL have port mret_req  input  1  mret retired.
REQ-010 SHALL have ports csr_we  input  1, csr_addr  input  12, csr_wdata  input  N, csr_rdata  output  N (combinational read).
REQ-011 SHALL have port interruptSignal  output  1  trap-entry redirect pulse to fetch.
REQ-012 SHALL have port PC_TrapTrigger  output  N  trap target, valid while interruptSignal=1.
REQ-013 SHALL have port trapReturn  output  1  mret redirect pulse to fetch.
REQ-014 SHALL have port PC_TrapReturn  output  N  equal to mepc at all times.
REQ-015 SHALL have port flush  output  1  pipeline flush, high during the redirect pulse and all refill cycles.

Function
REQ-016 SHALL implement states RUN, ENTRY, RETURN, REFILL.
REQ-017 SHALL, in RUN, sample events each cycle with priority exc_valid > pending enabled interrupt > mret_req; only the winner is acted on and the others are dropped.
REQ-018 SHALL treat an interrupt as pending-enabled only when mstatus.MIE=1 and irq[i]&mie[cause]; priority is external > software > timer.
REQ-019 SHALL, on an accepted exception or interrupt at edge t, enter ENTRY at t+1: interruptSignal=1 for exactly one cycle; mepc<=exc_pc (exception) or exc_pc input (interrupt, the next PC to execute); mcause<={interrupt bit N-1, cause}; MPIE<=MIE; MIE<=0.
REQ-020 SHALL, on accepted mret_req, enter RETURN for one cycle with trapReturn=1; MIE<=MPIE; MPIE<=1.
REQ-021 SHALL move from ENTRY/RETURN to REFILL, hold REFILL for exactly FLUSH_CYCLES cycles using a down-counter, then return to RUN; FLUSH_CYCLES=0 returns directly to RUN.
REQ-022 SHALL ignore exc_valid, irq and mret_req outside RUN, except that exc_valid in REFILL is also ignored (the flushed instruction is squashed).
REQ-023 SHALL ensure interruptSignal and trapReturn are never high in the same cycle.
REQ-024 SHALL implement CSRs mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, and mip 0x344 (read-only, reflects irq); unmapped addresses read 0 and ignore writes.
REQ-025 SHALL let trap-entry/mret updates override a same-cycle CSR write to mstatus/mepc/mcause; a same-cycle mtvec write takes effect for the next trap only.
REQ-026 SHALL compute PC_TrapTrigger = {mtvec[N-1:2],2'b00} unless vectored mode applies (REQ-029).

Reset
REQ-027 SHALL, while reset=1, force state RUN, counter 0, mtvec, mepc, mcause, mie, MIE, and MPIE to 0, and interruptSignal, trapReturn, and flush to 0; reset mid-REFILL aborts the refill.

Configuration
REQ-028 SHALL compile vectored trap mode only when TRAP_VECTORED_EN is defined.
REQ-029 SHALL, with TRAP_VECTORED_EN defined and mtvec[1:0]=01, set PC_TrapTrigger = base + 4*cause for interrupts and base for exceptions; without the macro, mtvec[1:0] read 0 and writes to them are ignored.

Structure
REQ-030 SHALL place the state enum, CSR address constants, and cause codes in shared package trap_pkg.
REQ-031 SHALL place the CSR file (registers, read mux, write decode) in sub-module trap_csr; the FSM, priority logic, and counter stay in trap_ctrl.

Verification
REQ-032 SHALL cover: mtvec=0x1000, exc_valid with cause 2 and exc_pc 0x200 -> next cycle interruptSignal=1, PC_TrapTrigger=0x1000, mepc=0x200, mcause=2, MIE=0, flush high for 4 cycles.
REQ-033 SHALL cover: MIE=1, mie[7]=1, irq=3'b011 with mie[3]=0 -> timer trap taken, mcause=0x8000_0000_0000_0007.
REQ-034 SHALL cover: with TRAP_VECTORED_EN, mtvec=0x1001, external irq -> PC_TrapTrigger=0x102C; without the macro -> 0x1000.
REQ-035 SHALL cover: exc_valid and mret_req in the same cycle -> only interruptSignal pulses, trapReturn stays 0.
REQ-036 SHALL cover: mret with MPIE=1, mepc=0x200 -> trapReturn=1, PC_TrapReturn=0x200, MIE=1, MPIE=1.
REQ-037 SHALL cover: exc_valid during REFILL is ignored, and reset asserted in REFILL -> RUN with all outputs 0 on the next cycle.
